// File: rtl/matrix_result_uart_tx_pkg.sv
// Shared constants, state encoding and byte selection for the 3x3 result UART transmitter.
// Row-major packing puts element [0][0] in the top byte; it is sent first.
package matrix_uart_pkg;

    localparam int MATRIX_ELEMS = 9;
    localparam int ELEM_W       = 8;
    localparam int MATRIX_W     = MATRIX_ELEMS * ELEM_W;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } tx_state_t;

    // Byte k of the packed matrix, k = 0 is the most significant byte.
    function automatic logic [ELEM_W-1:0] byte_sel(input logic [MATRIX_W-1:0] m,
                                                   input logic [3:0] k);
        return m[MATRIX_W - 1 - ELEM_W * int'(k) -: ELEM_W];
    endfunction

endpackage

// File: rtl/matrix_result_uart_tx_if.sv
// Request/status bundle between the matrix multiplier and the result transmitter.
// The master side supplies the matrix; the slave side reports progress and drives tx.
interface matrix_result_uart_tx_if;
    import matrix_uart_pkg::*;

    logic [MATRIX_W-1:0] result;
    logic                valid_in;
    logic                ready;
    logic                busy;
    logic                done;
    logic                tx;

    modport master (output result, valid_in, input ready, busy, done, tx);
    modport slave  (input result, valid_in, output ready, busy, done, tx);

endinterface

// File: rtl/matrix_result_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, one stop bit.
// A new byte may be loaded in the last stop-bit cycle so bytes can run back to back.
module uart_tx_byte
    import matrix_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       active,
    output logic       byte_done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;
    logic             can_load;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign byte_done = (state == STOP) && bit_end;
    assign can_load  = (state == IDLE) || byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            active    <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (start && can_load) begin
            state     <= START;
            tx        <= 1'b0;
            active    <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= data;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shift_reg[0];
                end
                // Shift right so the next bit to send is always at shift_reg[1].
                DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        bit_idx   <= bit_idx + 3'd1;
                        tx        <= shift_reg[1];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end
                end
                STOP: if (bit_end) begin
                    state   <= IDLE;
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/matrix_result_uart_tx.sv
// Sends a latched 3x3 result matrix as nine UART bytes, MSB byte first, with optional
// idle gaps between bytes and a done pulse in the first idle cycle after the last stop bit.
module matrix_result_uart_tx
    import matrix_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int GAP_BITS     = 1
) (
    input logic                    clk,
    input logic                    rst,
    matrix_result_uart_tx_if.slave bus
);

    localparam int              GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]      LAST_BYTE  = 4'(MATRIX_ELEMS - 1);

    tx_state_t           state;
    logic [MATRIX_W-1:0] hold;
    logic [3:0]          byte_idx;
    logic [GAP_W-1:0]    gap_cnt;
    logic                busy_q;
    logic                done_q;
    logic                accept;
    logic                chain_now;
    logic                gap_over;
    logic                start_byte;
    logic [3:0]          sel_idx;
    logic [7:0]          byte_data;
    logic                ser_tx;
    logic                byte_active;
    logic                byte_done;

    assign accept    = bus.valid_in && !busy_q;
    assign chain_now = (state == DATA) && byte_done && (byte_idx != LAST_BYTE) && (GAP_BITS == 0);
    assign gap_over  = (state == GAP) && (gap_cnt == GAP_LAST) && !byte_active;
    assign start_byte = accept || chain_now || gap_over;

    // Without a gap the next byte is loaded before byte_idx has advanced.
    assign sel_idx   = (state == DATA && byte_idx != LAST_BYTE) ? byte_idx + 4'd1 : byte_idx;
    assign byte_data = accept ? byte_sel(bus.result, 4'd0) : byte_sel(hold, sel_idx);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst      (rst),
        .data     (byte_data),
        .start    (start_byte),
        .tx       (ser_tx),
        .active   (byte_active),
        .byte_done(byte_done)
    );

    assign bus.tx    = ser_tx;
    assign bus.busy  = busy_q;
    assign bus.ready = ~busy_q;
    assign bus.done  = done_q;

    // DATA here means a byte is in flight inside the serialiser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    hold     <= bus.result;
                    byte_idx <= '0;
                    busy_q   <= 1'b1;
                    state    <= DATA;
                end
                DATA: if (byte_done) begin
                    if (byte_idx == LAST_BYTE) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                        if (GAP_BITS > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_over) begin
                        state   <= DATA;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_uart_tx.sv
// Bench for matrix_result_uart_tx: one instance with a one-bit gap, one without.
// Captures tx/done/busy per cycle and compares against a bit-level waveform model.
module tb_matrix_result_uart_tx;

    localparam int CPB = 87;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    logic tx_cap   [0:9000];
    logic done_cap [0:9000];
    logic busy_cap [0:9000];

    matrix_result_uart_tx_if if_g();
    matrix_result_uart_tx_if if_n();

    matrix_result_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(1)) dut_g (
        .clk(clk), .rst(rst), .bus(if_g)
    );
    matrix_result_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        else passes++;
    endtask

    task automatic applyStimulus(input logic [71:0] m, input bit nogap, input logic v);
        if (nogap) begin
            if_n.result = m; if_n.valid_in = v;
        end else begin
            if_g.result = m; if_g.valid_in = v;
        end
    endtask

    function automatic int frameLen(input int gap);
        return 90 * CPB + 8 * gap * CPB;
    endfunction

    // Expected line level j cycles after the acceptance edge, straight from 8N1 framing.
    function automatic logic expLevel(input logic [71:0] m, input int gap, input int j);
        int per, k, bitpos;
        logic [7:0] b;
        per = (10 + gap) * CPB;
        k = j / per;
        bitpos = (j % per) / CPB;
        if (k >= 9) return 1'b1;
        b = m[71 - 8 * k -: 8];
        if (bitpos == 0) return 1'b0;
        if (bitpos <= 8) return b[bitpos - 1];
        return 1'b1;
    endfunction

    task automatic checkIdle(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ({if_g.tx, if_g.busy, if_g.ready, if_g.done} !== 4'b1010) bad++;
            if ({if_n.tx, if_n.busy, if_n.ready, if_n.done} !== 4'b1010) bad++;
        end
        checkOutput(tag, 72'(bad), 72'd0);
    endtask

    task automatic checkFrame(input logic [71:0] m, input int gap, input string tag);
        int per, s, L, first_done, done_count;
        logic [7:0] dec;
        logic [71:0] mm;
        mm = m;
        per = (10 + gap) * CPB;
        L = frameLen(gap);
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 10; b++) begin
                s = k * per + b * CPB;
                checkOutput($sformatf("%s bit%0d.%0d", tag, k, b),
                            72'({tx_cap[s], tx_cap[s + CPB / 2], tx_cap[s + CPB - 1]}),
                            72'({3{expLevel(m, gap, s)}}));
                if (b >= 1 && b <= 8) dec[b - 1] = tx_cap[s + CPB / 2];
            end
            checkOutput($sformatf("%s byte%0d", tag, k), 72'(dec), 72'(mm[71 - 8 * k -: 8]));
            if (gap > 0 && k < 8)
                checkOutput($sformatf("%s gap%0d", tag, k),
                            72'({tx_cap[k * per + 10 * CPB], tx_cap[k * per + per - 1]}), 72'b11);
        end
        first_done = -1;
        done_count = 0;
        for (int j = 0; j <= L; j++) begin
            if (done_cap[j] === 1'b1) begin
                done_count++;
                if (first_done < 0) first_done = j;
            end
        end
        checkOutput({tag, " done_pos"}, 72'(first_done), 72'(L));
        checkOutput({tag, " done_count"}, 72'(done_count), 72'd1);
        checkOutput({tag, " end_state"}, 72'({busy_cap[L - 1], busy_cap[L], tx_cap[L]}), 72'b101);
    endtask

    // Assumes valid_in is set at a negedge; the following posedge is the acceptance edge.
    task automatic runFrame(input logic [71:0] m, input bit nogap, input bit hold,
                            input int inj_j, input logic [71:0] inj_m, input string tag);
        int L, gap;
        gap = nogap ? 0 : 1;
        L = frameLen(gap);
        applyStimulus(m, nogap, 1'b1);
        @(posedge clk);
        for (int j = 0; j <= L; j++) begin
            @(negedge clk);
            tx_cap[j]   = nogap ? if_n.tx   : if_g.tx;
            done_cap[j] = nogap ? if_n.done : if_g.done;
            busy_cap[j] = nogap ? if_n.busy : if_g.busy;
            if (j == 0 && !hold) applyStimulus({8'($urandom), 32'($urandom), 32'($urandom)}, nogap, 1'b0);
            if (j == inj_j) applyStimulus(inj_m, nogap, 1'b1);
            if (j == inj_j + 1) applyStimulus(inj_m, nogap, 1'b0);
        end
        if (!hold) applyStimulus(m, nogap, 1'b0);
        checkFrame(m, gap, tag);
    endtask

    initial begin
        logic [71:0] m, m2;
        int abort_j, bad;
        checks = 0;
        passes = 0;
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 72'({if_g.tx, if_g.busy, if_g.ready, if_g.done}), 72'b1010);
        rst = 1'b0;

        checkIdle("idle_1000", 1000);

        m = {8'd30, 8'd24, 8'd18, 8'd84, 8'd69, 8'd54, 8'd138, 8'd114, 8'd90};
        runFrame(m, 1'b0, 1'b0, -10, '0, "fixed_gap1");

        m = {8'h55, 32'($urandom), 32'($urandom)};
        runFrame(m, 1'b1, 1'b0, -10, '0, "nogap_55");

        m  = {8'($urandom), 32'($urandom), 32'($urandom)};
        m2 = ~m;
        runFrame(m, 1'b0, 1'b0, 3 * 11 * CPB + 5 * CPB, m2, "ignore_busy");

        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        abort_j = 4 * 11 * CPB + 4 * CPB + 10;
        applyStimulus(m, 1'b0, 1'b1);
        @(posedge clk);
        bad = 0;
        for (int j = 0; j <= abort_j; j++) begin
            @(negedge clk);
            if (j == 0) applyStimulus(m, 1'b0, 1'b0);
            if (if_g.done !== 1'b0) bad++;
            if (j == abort_j) checkOutput("abort_in_data", 72'(if_g.tx), 72'(expLevel(m, 1, j)));
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_reset", 72'({if_g.tx, if_g.busy, if_g.ready, if_g.done}), 72'b1010);
        rst = 1'b0;
        for (int j = 0; j < 2 * CPB; j++) begin
            @(negedge clk);
            if ({if_g.tx, if_g.done} !== 2'b10) bad++;
        end
        checkOutput("abort_no_done", 72'(bad), 72'd0);
        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        runFrame(m, 1'b0, 1'b0, -10, '0, "after_abort");

        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        runFrame(m, 1'b0, 1'b1, -10, '0, "b2b_first");
        checkOutput("b2b_idle_cycle", 72'({done_cap[frameLen(1)], tx_cap[frameLen(1)]}), 72'b11);
        runFrame(m, 1'b0, 1'b1, -10, '0, "b2b_second");
        checkOutput("b2b_restart", 72'(tx_cap[0]), 72'd0);
        applyStimulus(m, 1'b0, 1'b0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
